binarization_output_stream: RTL and testbench

- Streaming decoder for binarized activations: the inverse of the input binarization stage.
- Receives one channel-plane per handshake. A plane holds 1 bit per element for a single channel index.
- Counts ones per element across PARAM_CH_CNT planes and emits PARAM_IN_CNT reconstructed BIT-wide values through a valid/ready output.
- Sits between the binarized datapath and multi-bit consumers (next layer input, scoreboard dump).

---
 rtl/binarization_output_stream.sv | 114 +++++++++++
 tb/tb_binarization_output_stream.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/binarization_output_stream.sv
// Inverse of the input binarization stage: sums one channel bit per element over a
// group of planes and emits the saturated per-element counts as one output vector.
module binarization_output_stream #(
   parameter int PARAM_IN_CNT = 16,
   parameter int PARAM_IN_BIT = 8,
   parameter int PARAM_CH_CNT = 8
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      flush,
   input  logic                                      plane_valid,
   output logic                                      plane_ready,
   input  logic [PARAM_IN_CNT-1:0]                   plane_data,
   output logic                                      value_valid,
   input  logic                                      value_ready,
   output logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT-1:0] value_out,
   output logic [$clog2(PARAM_CH_CNT+1)-1:0]         plane_cnt
);

   localparam int CW = $clog2(PARAM_CH_CNT + 1);
   localparam int SW = ((CW > PARAM_IN_BIT) ? CW : PARAM_IN_BIT) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(PARAM_CH_CNT - 1);
   localparam logic [SW-1:0] MAX_VAL  = SW'({PARAM_IN_BIT{1'b1}});

   typedef enum logic {
      ST_ACCUM,
      ST_OUTPUT
   } state_t;

   state_t                                  r_state;
   state_t                                  w_state_next;
   logic [CW-1:0]                           r_cnt [PARAM_IN_CNT];
   logic [CW-1:0]                           r_plane_cnt;
   logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT-1:0] r_value;
   logic [CW-1:0]                           w_sum [PARAM_IN_CNT];
   logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT-1:0] w_sat;
   logic                                    w_accept;
   logic                                    w_last;

   assign w_accept = plane_valid && (r_state == ST_ACCUM) && !flush;
   assign w_last   = (r_plane_cnt == LAST_IDX);

   // Sum includes the plane being accepted so the final plane lands directly in value_out.
   generate
      for (genvar gi = 0; gi < PARAM_IN_CNT; gi++) begin : g_elem
         assign w_sum[gi] = r_cnt[gi] + CW'(plane_data[gi]);
         assign w_sat[gi] = (SW'(w_sum[gi]) > MAX_VAL) ? {PARAM_IN_BIT{1'b1}}
                                                        : PARAM_IN_BIT'(w_sum[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      plane_ready  = 1'b0;
      value_valid  = 1'b0;
      unique case (r_state)
         ST_ACCUM: begin
            plane_ready = !flush;
            if (w_accept && w_last) begin
               w_state_next = ST_OUTPUT;
            end
         end
         ST_OUTPUT: begin
            value_valid = 1'b1;
            if (value_ready) begin
               w_state_next = ST_ACCUM;
            end
         end
         default: w_state_next = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < PARAM_IN_CNT; j++) begin
            r_cnt[j] <= '0;
         end
         r_plane_cnt <= '0;
         r_value     <= '0;
      end else if (r_state == ST_ACCUM) begin
         if (flush) begin
            for (int j = 0; j < PARAM_IN_CNT; j++) begin
               r_cnt[j] <= '0;
            end
            r_plane_cnt <= '0;
         end else if (w_accept) begin
            if (w_last) begin
               r_value <= w_sat;
               for (int j = 0; j < PARAM_IN_CNT; j++) begin
                  r_cnt[j] <= '0;
               end
               r_plane_cnt <= '0;
            end else begin
               for (int j = 0; j < PARAM_IN_CNT; j++) begin
                  r_cnt[j] <= w_sum[j];
               end
               r_plane_cnt <= r_plane_cnt + CW'(1);
            end
         end
      end
   end

   assign value_out = r_value;
   assign plane_cnt = r_plane_cnt;

endmodule

// File: tb/tb_binarization_output_stream.sv
// Bench: two instances (4-bit and 2-bit outputs) share stimulus; a popcount model
// predicts handshake and value behaviour every cycle.
module tb_binarization_output_stream;

   localparam int N  = 4;
   localparam int B  = 4;
   localparam int B2 = 2;
   localparam int CH = 8;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                flush = 1'b0;
   logic                plane_valid = 1'b0;
   logic                value_ready = 1'b0;
   logic [N-1:0]        plane_data = '0;
   logic                plane_ready, value_valid, plane_ready2, value_valid2;
   logic [N-1:0][B-1:0]  value_out;
   logic [N-1:0][B2-1:0] value_out2;
   logic [3:0]          plane_cnt, plane_cnt2;

   int tests = 0;
   int fails = 0;
   int dut_groups = 0;
   bit rand_vr = 1'b0;

   // model state
   int m_cnt [N];
   int m_held [N];
   int m_np = 0;
   int m_in_out = 0;
   int m_groups = 0;

   binarization_output_stream #(.PARAM_IN_CNT(N), .PARAM_IN_BIT(B), .PARAM_CH_CNT(CH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .plane_valid(plane_valid), .plane_ready(plane_ready),
      .plane_data(plane_data), .value_valid(value_valid), .value_ready(value_ready),
      .value_out(value_out), .plane_cnt(plane_cnt));

   binarization_output_stream #(.PARAM_IN_CNT(N), .PARAM_IN_BIT(B2), .PARAM_CH_CNT(CH)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush), .plane_valid(plane_valid), .plane_ready(plane_ready2),
      .plane_data(plane_data), .value_valid(value_valid2), .value_ready(value_ready),
      .value_out(value_out2), .plane_cnt(plane_cnt2));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_val4();
      logic [15:0] r;
      r = '0;
      for (int j = 0; j < N; j++) r[j*4 +: 4] = 4'((m_held[j] > 15) ? 15 : m_held[j]);
      return r;
   endfunction

   function automatic logic [7:0] exp_val2();
      logic [7:0] r;
      r = '0;
      for (int j = 0; j < N; j++) r[j*2 +: 2] = 2'((m_held[j] > 3) ? 3 : m_held[j]);
      return r;
   endfunction

   // Behavioural model: a group of CH accepted planes produces popcounts per element.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < N; j++) begin
            m_cnt[j]  = 0;
            m_held[j] = 0;
         end
         m_np = 0;
         m_in_out = 0;
      end else if (m_in_out != 0) begin
         if (value_ready) m_in_out = 0;
      end else if (flush) begin
         for (int j = 0; j < N; j++) m_cnt[j] = 0;
         m_np = 0;
      end else if (plane_valid) begin
         for (int j = 0; j < N; j++) m_cnt[j] += int'(plane_data[j]);
         m_np++;
         if (m_np == CH) begin
            m_held = m_cnt;
            for (int j = 0; j < N; j++) m_cnt[j] = 0;
            m_np = 0;
            m_in_out = 1;
            m_groups++;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("plane_ready", 32'(plane_ready), 32'((m_in_out == 0) && !flush));
         chk("plane_ready_sat", 32'(plane_ready2), 32'((m_in_out == 0) && !flush));
         chk("value_valid", 32'(value_valid), 32'(m_in_out != 0));
         chk("value_valid_sat", 32'(value_valid2), 32'(m_in_out != 0));
         chk("plane_cnt", 32'(plane_cnt), 32'(m_np));
         chk("plane_cnt_sat", 32'(plane_cnt2), 32'(m_np));
         chk("value_out", 32'(value_out), 32'(exp_val4()));
         chk("value_out_sat", 32'(value_out2), 32'(exp_val2()));
         if (value_valid && value_ready) begin
            dut_groups++;
            $display("[TB] group %0d value_out=%h sat=%h", dut_groups, value_out, value_out2);
         end
      end
   end

   task automatic push_plane(input logic [N-1:0] d);
      int t;
      t = 0;
      plane_valid = 1'b1;
      plane_data  = d;
      forever begin
         if (rand_vr) value_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (plane_ready) break;
         t++;
         if (t > 100) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: plane_ready=%b required 1 at %0t", plane_ready, $time);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      plane_valid = 1'b0;
      plane_data  = N'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         plane_valid = 1'b0;
         plane_data  = N'($urandom);
         if (rand_vr) value_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_plane_cnt", 32'(plane_cnt), 32'd0);
      chk("rst_value_valid", 32'(value_valid), 32'd0);
      chk("rst_value_out", 32'(value_out), 32'd0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_plane_ready", 32'(plane_ready), 32'd1);
      @(posedge clk); #1;

      // Basic group: elements 3..0 = 5,5,5,8
      value_ready = 1'b1;
      repeat (5) push_plane(4'b1111);
      repeat (3) push_plane(4'b0001);
      @(negedge clk);
      chk("basic_valid", 32'(value_valid), 32'd1);
      chk("basic_out", 32'(value_out), 32'h5558);
      chk("basic_sat_out", 32'(value_out2), 32'hFF);
      chk("basic_cnt", 32'(plane_cnt), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("basic_drop", 32'(value_valid), 32'd0);
      chk("basic_hold", 32'(value_out), 32'h5558);
      @(posedge clk); #1;

      // Backpressure: output holds while planes stall
      value_ready = 1'b0;
      repeat (5) push_plane(4'b1111);
      repeat (3) push_plane(4'b0001);
      plane_valid = 1'b1;
      plane_data  = 4'b1010;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 32'(value_valid), 32'd1);
         chk("bp_ready", 32'(plane_ready), 32'd0);
         chk("bp_hold", 32'(value_out), 32'h5558);
         @(posedge clk); #1;
      end
      value_ready = 1'b1;
      repeat (8) push_plane(4'b1010);
      @(negedge clk);
      chk("bp_next", 32'(value_out), 32'h8080);
      chk("bp_next_sat", 32'(value_out2), 32'hCC);
      @(posedge clk); #1;

      // Flush discards a partial group and blocks the plane presented with it
      repeat (3) push_plane(4'b1111);
      flush = 1'b1;
      plane_valid = 1'b1;
      plane_data = 4'b1111;
      @(negedge clk);
      chk("flush_ready", 32'(plane_ready), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      plane_valid = 1'b0;
      @(negedge clk);
      chk("flush_cnt", 32'(plane_cnt), 32'd0);
      @(posedge clk); #1;
      repeat (8) push_plane(4'b0000);
      @(negedge clk);
      chk("flush_valid", 32'(value_valid), 32'd1);
      chk("flush_out", 32'(value_out), 32'h0000);
      @(posedge clk); #1;

      // Asynchronous reset mid-group
      repeat (4) push_plane(4'b1111);
      chk("pre_rst_cnt", 32'(plane_cnt), 32'd4);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_cnt", 32'(plane_cnt), 32'd0);
      chk("async_rst_valid", 32'(value_valid), 32'd0);
      #4 rst = 1'b0;
      @(posedge clk); #1;
      repeat (8) push_plane(4'b0010);
      @(negedge clk);
      chk("post_rst_out", 32'(value_out), 32'h0080);
      chk("post_rst_sat", 32'(value_out2), 32'h0C);
      @(posedge clk); #1;

      // Random groups with idle gaps and random backpressure
      dut_groups = 0;
      m_groups = 0;
      rand_vr = 1'b1;
      for (int g = 0; g < 200; g++) begin
         for (int p = 0; p < CH; p++) begin
            idle($urandom_range(0, 2));
            push_plane(N'($urandom));
         end
      end
      rand_vr = 1'b0;
      value_ready = 1'b1;
      idle(4);
      chk("groups_model", 32'(m_groups), 32'd200);
      chk("groups_dut", 32'(dut_groups), 32'd200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
